mult_sequencer: RTL and testbench

Sequencer that sits between the pipeline's execute stage and the 32-bit iterative Booth multiplier. It latches operands on a start pulse and holds them stable for the whole operation. It restarts the multiplier through its clear input, gates its enable, and waits for its ready flag. It then returns a registered result, an exception flag and a one-cycle completion pulse, and adds a zero-operand fast path, restart-on-new-request and a watchdog timeout.

---
 rtl/mult_sequencer_if.sv | 39 +++
 rtl/mult_sequencer.sv | 126 ++++++++++++
 tb/tb_mult_sequencer.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_sequencer_if.sv
// Bus bundle between the execute stage, the sequencer and the iterative
// Booth multiplier. The sequencer uses the slave view. The environment
// (execute stage plus multiplier) uses the master view.
interface mult_sequencer_if #(
    parameter int WIDTH = 32
);
    // execute-stage request side
    logic             ctrl_MULT;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    // multiplier side
    logic [WIDTH-1:0] mul_cand;
    logic [WIDTH-1:0] mul_plier;
    logic             mul_clrn;
    logic             mul_ena;
    logic             mul_ready;
    logic [WIDTH-1:0] mul_out;
    logic             mul_overflow;
    // execute-stage response side
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;
    logic             timeout_err;

    modport slave (
        input  ctrl_MULT, data_operandA, data_operandB,
        input  mul_ready, mul_out, mul_overflow,
        output mul_cand, mul_plier, mul_clrn, mul_ena,
        output data_result, data_exception, data_resultRDY, busy, timeout_err
    );

    modport master (
        output ctrl_MULT, data_operandA, data_operandB,
        output mul_ready, mul_out, mul_overflow,
        input  mul_cand, mul_plier, mul_clrn, mul_ena,
        input  data_result, data_exception, data_resultRDY, busy, timeout_err
    );
endinterface

// File: rtl/mult_sequencer.sv
// Sequencer in front of the 32-bit iterative Booth multiplier. It latches
// operands on a start pulse, clears and enables the multiplier, and waits
// for ready under a watchdog. It returns a registered product, an exception
// flag and a one-cycle completion pulse. A zero operand short-circuits the
// multiplier, and a new start in any state aborts the operation in flight.
module mult_sequencer #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 40
) (
    input  logic               clk,
    input  logic               clrn,
    mult_sequencer_if.slave    bus
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] cand_q;
    logic [WIDTH-1:0] plier_q;
    logic             mul_clrn_q;
    logic             mul_ena_q;
    logic [WIDTH-1:0] result_q;
    logic             exc_q;
    logic             rdy_q;
    logic             busy_q;
    logic             tmo_q;
    logic [CW-1:0]    cnt_q;

    logic             zero_op;

    // Either operand zero means the product is zero, so the multiplier is skipped.
    assign zero_op = (bus.data_operandA == '0) || (bus.data_operandB == '0);

    // Single FSM. A start pulse takes priority in every state, which gives
    // restart-on-request for free. In RUN, ready is checked before the watchdog.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q    <= S_IDLE;
            cand_q     <= '0;
            plier_q    <= '0;
            mul_clrn_q <= 1'b0;
            mul_ena_q  <= 1'b0;
            result_q   <= '0;
            exc_q      <= 1'b0;
            rdy_q      <= 1'b0;
            busy_q     <= 1'b0;
            tmo_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            rdy_q <= 1'b0;
            if (bus.ctrl_MULT) begin
                // Latch operands. They stay frozen until the next start.
                cand_q    <= bus.data_operandA;
                plier_q   <= bus.data_operandB;
                cnt_q     <= '0;
                mul_ena_q <= 1'b0;
                if (zero_op) begin
                    state_q    <= S_DONE;
                    result_q   <= '0;
                    exc_q      <= 1'b0;
                    rdy_q      <= 1'b1;
                    mul_clrn_q <= 1'b1;
                    busy_q     <= 1'b0;
                end else begin
                    state_q    <= S_CLEAR;
                    mul_clrn_q <= 1'b0;
                    busy_q     <= 1'b1;
                end
            end else begin
                case (state_q)
                    S_CLEAR: begin
                        state_q    <= S_RUN;
                        mul_clrn_q <= 1'b1;
                        mul_ena_q  <= 1'b1;
                        busy_q     <= 1'b1;
                        cnt_q      <= '0;
                    end
                    S_RUN: begin
                        if (bus.mul_ready) begin
                            state_q   <= S_DONE;
                            result_q  <= bus.mul_out;
                            exc_q     <= bus.mul_overflow;
                            rdy_q     <= 1'b1;
                            mul_ena_q <= 1'b0;
                            busy_q    <= 1'b0;
                        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                            // TIMEOUT-th RUN cycle without ready: abort with exception.
                            state_q   <= S_DONE;
                            result_q  <= '0;
                            exc_q     <= 1'b1;
                            tmo_q     <= 1'b1;
                            rdy_q     <= 1'b1;
                            mul_ena_q <= 1'b0;
                            busy_q    <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        // IDLE and DONE both settle into IDLE with the multiplier released.
                        state_q    <= S_IDLE;
                        mul_clrn_q <= 1'b1;
                        mul_ena_q  <= 1'b0;
                        busy_q     <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.mul_cand       = cand_q;
    assign bus.mul_plier      = plier_q;
    assign bus.mul_clrn       = mul_clrn_q;
    assign bus.mul_ena        = mul_ena_q;
    assign bus.data_result    = result_q;
    assign bus.data_exception = exc_q;
    assign bus.data_resultRDY = rdy_q;
    assign bus.busy           = busy_q;
    assign bus.timeout_err    = tmo_q;
endmodule

// File: tb/tb_mult_sequencer.sv
// Bench for mult_sequencer. It contains a cycle-counting multiplier stub
// with a programmable iteration count, and a per-cycle operation model that
// predicts the result pulse, busy window, enable/clear activity, result
// registers and the sticky timeout flag. It also makes literal checks at
// key points.
module tb_mult_sequencer;
    localparam int WIDTH   = 32;
    localparam int TIMEOUT = 40;

    logic clk  = 1'b0;
    logic clrn = 1'b0;

    mult_sequencer_if #(.WIDTH(WIDTH)) bus ();

    mult_sequencer #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;
    int pos_n  = 0;

    always @(posedge clk) pos_n <= pos_n + 1;

    // ---------------- multiplier stub ----------------
    int stub_cnt   = 0;
    int stub_iters = 32;

    function automatic longint sprod(input logic [31:0] a, input logic [31:0] b);
        longint pa;
        longint pb;
        pa = longint'($signed(a));
        pb = longint'($signed(b));
        return pa * pb;
    endfunction

    function automatic logic prod_ovf(input logic [31:0] a, input logic [31:0] b);
        longint p;
        logic [31:0] lo;
        p  = sprod(a, b);
        lo = p[31:0];
        return p != longint'($signed(lo));
    endfunction

    function automatic logic [31:0] prod_lo(input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = sprod(a, b);
        return p[31:0];
    endfunction

    always @(posedge clk) begin
        if (!bus.mul_clrn)    stub_cnt <= 0;
        else if (bus.mul_ena) stub_cnt <= stub_cnt + 1;
    end

    assign bus.mul_ready    = bus.mul_ena && (stub_cnt == stub_iters - 1);
    assign bus.mul_out      = prod_lo(bus.mul_cand, bus.mul_plier);
    assign bus.mul_overflow = prod_ovf(bus.mul_cand, bus.mul_plier);

    // ---------------- operation model ----------------
    // Cycle k of an operation (k=1 right after the sampling edge) is the cycle
    // in which pos_n == m_s + k - 1.
    logic        m_active = 1'b0;
    logic        m_nz     = 1'b0;
    int          m_s      = 0;
    int          m_rdy_at = 0;
    logic [31:0] m_new_res = '0;
    logic        m_new_exc = 1'b0;
    logic        m_new_tmo = 1'b0;
    logic [31:0] m_res  = '0;
    logic        m_exc  = 1'b0;
    logic        m_tmo  = 1'b0;
    logic [31:0] m_cand = '0;
    logic [31:0] m_plier = '0;
    int          rst_pos = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @pos %0d: got %h expected %h", name, pos_n, act, exp);
        end
    endtask

    // Per-cycle comparison against the model, sampled on the falling edge.
    always @(negedge clk) begin
        logic e_rdy, e_busy, e_ena, e_clrn_low;
        if (m_active && pos_n == m_rdy_at) begin
            m_res = m_new_res;
            m_exc = m_new_exc;
            if (m_new_tmo) m_tmo = 1'b1;
        end
        e_rdy      = m_active && (pos_n == m_rdy_at);
        e_busy     = m_active && m_nz && (pos_n >= m_s) && (pos_n < m_rdy_at);
        e_ena      = m_active && m_nz && (pos_n > m_s) && (pos_n < m_rdy_at);
        e_clrn_low = m_active && m_nz && (pos_n == m_s);
        chk("resultRDY", 32'(bus.data_resultRDY), 32'(e_rdy));
        chk("busy",      32'(bus.busy),           32'(e_busy));
        chk("mul_ena",   32'(bus.mul_ena),        32'(e_ena));
        chk("result",    bus.data_result,         m_res);
        chk("exception", 32'(bus.data_exception), 32'(m_exc));
        chk("timeout",   32'(bus.timeout_err),    32'(m_tmo));
        chk("cand",      bus.mul_cand,            m_cand);
        chk("plier",     bus.mul_plier,           m_plier);
        if (clrn && pos_n > rst_pos)
            chk("mul_clrn", 32'(bus.mul_clrn), 32'(!e_clrn_low));
    end

    // ---------------- driver ----------------
    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called at posedge+1. Pulses start for one cycle, then records the prediction.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        int k;
        bus.data_operandA = a;
        bus.data_operandB = b;
        bus.ctrl_MULT     = 1'b1;
        @(posedge clk);
        #1;
        bus.ctrl_MULT     = 1'b0;
        bus.data_operandA = 32'hDEAD_BEEF;
        bus.data_operandB = 32'hC0FF_EE11;
        m_cand   = a;
        m_plier  = b;
        m_active = 1'b1;
        m_s      = pos_n;
        m_nz     = (a != 0) && (b != 0);
        m_new_tmo = 1'b0;
        if (!m_nz) begin
            k = 1;
            m_new_res = '0;
            m_new_exc = 1'b0;
        end else if (stub_iters <= TIMEOUT) begin
            k = stub_iters + 2;
            m_new_res = prod_lo(a, b);
            m_new_exc = prod_ovf(a, b);
        end else begin
            k = TIMEOUT + 2;
            m_new_res = '0;
            m_new_exc = 1'b1;
            m_new_tmo = 1'b1;
        end
        m_rdy_at = m_s + k - 1;
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_res    = '0;
        m_exc    = 1'b0;
        m_tmo    = 1'b0;
        m_cand   = '0;
        m_plier  = '0;
    endtask

    initial begin
        bus.ctrl_MULT     = 1'b0;
        bus.data_operandA = '0;
        bus.data_operandB = '0;
        model_reset();
        #1;
        // Reset state
        chk("rst_result",  bus.data_result, 32'h0);
        chk("rst_clrn",    32'(bus.mul_clrn), 32'h0);
        chk("rst_rdy",     32'(bus.data_resultRDY), 32'h0);
        wait_cyc(2);
        clrn    = 1'b1;
        rst_pos = pos_n;
        wait_cyc(3);

        // 3*4 with 32 iterations: pulse 34 cycles after start, one cycle wide
        start_op(32'd3, 32'd4);
        chk("lit_busy_c1", 32'(bus.busy), 32'h1);
        wait_cyc(33);
        chk("lit_3x4_rdy", 32'(bus.data_resultRDY), 32'h1);
        chk("lit_3x4_res", bus.data_result, 32'd12);
        chk("lit_3x4_exc", 32'(bus.data_exception), 32'h0);
        wait_cyc(1);
        chk("lit_3x4_rdy_off", 32'(bus.data_resultRDY), 32'h0);
        wait_cyc(2);

        // overflow case, then back-to-back start in its DONE cycle
        start_op(32'h7FFF_FFFF, 32'd2);
        wait_cyc(33);
        chk("lit_ovf_res", bus.data_result, 32'hFFFF_FFFE);
        chk("lit_ovf_exc", 32'(bus.data_exception), 32'h1);
        start_op(32'hFFFF_FFFB, 32'd7);
        chk("lit_b2b_busy", 32'(bus.busy), 32'h1);
        wait_cyc(33);
        chk("lit_neg_res", bus.data_result, 32'hFFFF_FFDD);
        chk("lit_neg_exc", 32'(bus.data_exception), 32'h0);
        wait_cyc(2);

        // zero path
        start_op(32'd0, 32'h1234);
        chk("lit_zero_rdy", 32'(bus.data_resultRDY), 32'h1);
        chk("lit_zero_res", bus.data_result, 32'h0);
        wait_cyc(3);

        // restart at RUN cycle 10
        start_op(32'd6, 32'd7);
        wait_cyc(10);
        start_op(32'd5, 32'd5);
        wait_cyc(33);
        chk("lit_restart_res", bus.data_result, 32'd25);
        wait_cyc(2);

        // restart coinciding with ready: restart wins
        start_op(32'd2, 32'd2);
        wait_cyc(32);
        start_op(32'd3, 32'd3);
        wait_cyc(33);
        chk("lit_race_res", bus.data_result, 32'd9);
        wait_cyc(2);

        // ready on the watchdog's last cycle: ready wins
        stub_iters = TIMEOUT;
        start_op(32'd4, 32'd5);
        wait_cyc(TIMEOUT + 1);
        chk("lit_edge_res", bus.data_result, 32'd20);
        chk("lit_edge_tmo", 32'(bus.timeout_err), 32'h0);
        wait_cyc(2);

        // watchdog timeout, then sticky flag across a good operation
        stub_iters = 1000;
        start_op(32'd2, 32'd3);
        wait_cyc(TIMEOUT + 1);
        chk("lit_tmo_rdy", 32'(bus.data_resultRDY), 32'h1);
        chk("lit_tmo_res", bus.data_result, 32'h0);
        chk("lit_tmo_exc", 32'(bus.data_exception), 32'h1);
        stub_iters = 32;
        wait_cyc(2);
        start_op(32'd7, 32'd8);
        wait_cyc(33);
        chk("lit_after_tmo_res", bus.data_result, 32'd56);
        chk("lit_sticky_tmo", 32'(bus.timeout_err), 32'h1);
        wait_cyc(2);

        // async reset at RUN cycle 15
        start_op(32'd10, 32'd10);
        wait_cyc(15);
        #2;
        clrn = 1'b0;
        model_reset();
        #1;
        chk("arst_busy",  32'(bus.busy), 32'h0);
        chk("arst_ena",   32'(bus.mul_ena), 32'h0);
        chk("arst_clrn",  32'(bus.mul_clrn), 32'h0);
        chk("arst_tmo",   32'(bus.timeout_err), 32'h0);
        chk("arst_res",   bus.data_result, 32'h0);
        chk("arst_cand",  bus.mul_cand, 32'h0);
        wait_cyc(2);
        clrn    = 1'b1;
        rst_pos = pos_n;
        wait_cyc(2);
        start_op(32'd9, 32'd9);
        wait_cyc(33);
        chk("lit_post_rst_rdy", 32'(bus.data_resultRDY), 32'h1);
        chk("lit_post_rst_res", bus.data_result, 32'd81);
        wait_cyc(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
